uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM state type and bit-timing helper for the UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Integer truncation is intentional: the bit period is a whole number of clocks.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Show-ahead circular FIFO buffering bytes awaiting transmission.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Buffered UART transmitter, 8N1 frames by default; defining
//               UART_TX_PARITY_EN inserts an even-parity bit after the data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BIT_RATE     = 256000,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx,
    output logic                    busy
);

    localparam int                  c_cycles_per_bit = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int                  c_baud_w  = (c_cycles_per_bit > 1) ? $clog2(c_cycles_per_bit) : 1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_cycles_per_bit - 1);
    localparam int                  c_idx_w   = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(PAYLOAD_BITS - 1);
    localparam int                  c_cnt_w   = $clog2(FIFO_DEPTH) + 1;

    uart_state_t             r_state;
    uart_state_t             w_state_next;
    logic [c_baud_w-1:0]     r_baud_cnt;
    logic [c_baud_w-1:0]     w_baud_next;
    logic [c_idx_w-1:0]      r_bit_idx;
    logic [c_idx_w-1:0]      w_bit_idx_next;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_tx;
    logic                    r_busy;
    logic                    r_ready_en;
    logic                    w_tx_next;
    logic                    w_bit_end;
    logic                    w_push;
    logic                    w_pop;
    logic [PAYLOAD_BITS-1:0] w_fifo_rd_data;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [c_cnt_w-1:0]      w_fifo_count;

    // r_ready_en holds tx_ready low during reset and for the reset edge itself.
    assign tx_ready  = r_ready_en & ~w_fifo_full;
    assign w_push    = tx_valid & tx_ready;
    assign w_bit_end = (r_baud_cnt == c_baud_last);
    assign tx        = r_tx;
    assign busy      = r_busy;

    uart_tx_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .wr_data (tx_data),
        .pop     (w_pop),
        .rd_data (w_fifo_rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_pop          = 1'b0;
        w_baud_next    = (r_state == IDLE || w_bit_end) ? '0 : r_baud_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == c_idx_last) begin
                        w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next   = PARITY;
`else
                        w_state_next   = STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    logic w_parity;
    assign w_parity = ^r_data;
`endif

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_data[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = w_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            if (w_pop) begin
                r_data <= w_fifo_rd_data;
            end
            r_tx       <= w_tx_next;
            r_busy     <= w_push | (w_fifo_count != '0) | (r_state != IDLE);
            r_ready_en <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx at default parameters; frame
//               format follows UART_TX_PARITY_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 390;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         busy_fall = -1;
    logic       busy_prev = 1'b0;
    logic       abort_req = 1'b0;
    logic       mon_active = 1'b0;
    logic [7:0] exp_q[$];
    int         starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Monitor: every frame on the line is compared sample-by-sample with the scoreboard head.
    initial begin
        logic [7:0] e;
        logic [7:0] got;
        int         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                starts.push_back(cyc);
                mon_active = 1'b1;
                e = 8'h00;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame_expected: frame started at cycle %0d, required no frame", cyc);
                end else begin
                    e = exp_q.pop_front();
                end
                bad = 0;
                got = 8'h00;
                aborted = 0;
                for (int k = 0; k < FRAME_CYC; k++) begin
                    if (k > 0) @(negedge clk);
                    if (abort_req) begin
                        aborted = 1;
                        break;
                    end
                    if (tx !== exp_bit(e, k / CPB)) bad++;
                    if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8)
                        got[k / CPB - 1] = tx;
                end
                if (!aborted) begin
                    n_vec++;
                    if (bad != 0) begin
                        n_err++;
                        $display("FAIL frame: got 8'h%02h, required 8'h%02h (%0d bad samples)", got, e, bad);
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, output int acc, output int waited);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        waited   = 0;
        while (tx_ready !== 1'b1 && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 10000) check_int("accept_timeout", waited, 0);
        acc = cyc + 1;
        exp_q.push_back(d);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((busy !== 1'b0 || mon_active) && w < limit);
        check_int("idle_in_time", int'(w < limit), 1);
        @(negedge clk);
    endtask

    task automatic single_frame(input logic [7:0] d, input string tag);
        int acc;
        int w;
        starts.delete();
        send_byte(d, acc, w);
        drop_valid();
        check_bit({tag, "_busy_after_accept"}, busy, 1'b1);
        wait_idle(FRAME_CYC + 2000);
        if (starts.size() != 1) begin
            check_int({tag, "_frames_seen"}, starts.size(), 1);
        end else begin
            check_int({tag, "_latency"}, starts[0] - acc, 2);
            check_int({tag, "_busy_len"}, busy_fall - starts[0], FRAME_CYC);
        end
    endtask

    initial begin
        int         acc;
        int         w;
        int         waits;
        int         lows;
        logic [7:0] c_bytes [6];
        c_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        repeat (3) @(negedge clk);
        check_bit("rst_tx", tx, 1'b1);
        check_bit("rst_ready", tx_ready, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_bit("ready_after_rst", tx_ready, 1'b1);

        single_frame(8'h5F, "a5f");
        single_frame(8'h07, "b07");

        // Back-to-back pushes: start bits must be exactly one frame apart.
        starts.delete();
        send_byte(8'h2A, acc, w);
        send_byte(8'h42, acc, w);
        send_byte(8'h7A, acc, w);
        drop_valid();
        wait_idle(3 * FRAME_CYC + 2000);
        if (starts.size() != 3) begin
            check_int("b2b_frames", starts.size(), 3);
        end else begin
            check_int("b2b_gap1", starts[1] - starts[0], FRAME_CYC);
            check_int("b2b_gap2", starts[2] - starts[1], FRAME_CYC);
        end

        // Six pushes with tx_valid held: the sixth must stall until a slot frees.
        starts.delete();
        waits = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(c_bytes[i], acc, w);
            if (i < 5) waits += w;
            else check_int("sixth_stalled", int'(w > 0), 1);
        end
        check_int("first_five_no_stall", waits, 0);
        drop_valid();
        wait_idle(6 * FRAME_CYC + 2000);
        check_int("full_frames", starts.size(), 6);

        // Reset mid-DATA with two bytes still queued.
        starts.delete();
        send_byte(8'h42, acc, w);
        send_byte(8'h55, acc, w);
        send_byte(8'hAA, acc, w);
        drop_valid();
        w = 0;
        while (starts.size() == 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check_int("rst_frame_started", starts.size(), 1);
        repeat (3 * CPB) @(negedge clk);
        abort_req = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("midrst_tx", tx, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_ready_low", tx_ready, 1'b0);
        exp_q.delete();
        @(negedge clk);
        check_bit("midrst_ready_back", tx_ready, 1'b1);
        abort_req = 1'b0;
        starts.delete();
        lows = 0;
        repeat (2 * FRAME_CYC) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check_int("quiet_after_rst", lows, 0);
        check_int("no_frames_after_rst", starts.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
